// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling stage.
package pool_pkg;

  typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_t;

  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Replicates an in_res-bit value MSB-first to fill out_res bits (0xA -> 0xAA).
  function automatic logic [31:0] depth_expand(input logic [31:0] value, input int in_res,
                                               input int out_res);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < out_res) r[out_res-1-i] = value[in_res-1-(i % in_res)];
    return r;
  endfunction

endpackage

// File: rtl/pool_combine.sv
// One accumulate step: load on pool start, else add (average) or keep the larger (max).
module pool_combine
  import pool_pkg::*;
#(
  parameter int IN_RES = 1,
  parameter int ACC_W  = 3
) (
  input  pool_mode_t         mode,
  input  logic               start,
  input  logic [ACC_W-1:0]   entry,
  input  logic [IN_RES-1:0]  pixel,
  output logic [ACC_W-1:0]   next_entry
);

  logic [ACC_W-1:0] pix_ext;
  assign pix_ext = ACC_W'(pixel);

  always_comb begin
    next_entry = entry + pix_ext;
    if (start)                 next_entry = pix_ext;
    else if (mode == POOL_MAX) next_entry = (pix_ext > entry) ? pix_ext : entry;
  end

endmodule

// File: rtl/stream_pooling_n.sv
// Raster-streaming NxN average/max pooling with a one-deep output register.
// Build option: STREAM_POOLING_ROUND_EN selects round-half-up averaging instead of truncation.
module stream_pooling_n
  import pool_pkg::*;
#(
  parameter int IN_RES  = 1,
  parameter int OUT_RES = 8,
  parameter int N       = 2,
  parameter int IN_SIDE = 28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_RES-1:0]  in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_RES-1:0] out_pixel,
  output logic               out_last
);

  localparam int OUT_SIDE = IN_SIDE / N;
  localparam int LOGN     = clog2_int(N);
  localparam int ACC_W    = IN_RES + 2 * LOGN;
  localparam int CNT_W    = clog2_int(IN_SIDE);
  localparam int IDX_W    = (OUT_SIDE > 1) ? clog2_int(OUT_SIDE) : 1;
  localparam logic [CNT_W-1:0] SIDE_MAX = CNT_W'(IN_SIDE - 1);

  logic [CNT_W-1:0]  row, col;
  pool_mode_t        mode_q, mode_eff;
  logic [ACC_W-1:0]  acc [OUT_SIDE];
  logic [ACC_W-1:0]  entry_next;
  logic [IDX_W-1:0]  idx;
  logic [IN_RES-1:0] avg;
  logic              accept, first_px, start, done, frame_end;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign first_px  = (row == '0) && (col == '0);
  // The first pixel of a frame uses the live mode pin; the rest of the frame uses the latch.
  assign mode_eff  = first_px ? pool_mode_t'(mode) : mode_q;
  assign start     = (row[LOGN-1:0] == '0) && (col[LOGN-1:0] == '0);
  assign done      = accept && (&row[LOGN-1:0]) && (&col[LOGN-1:0]);
  assign frame_end = (row == SIDE_MAX) && (col == SIDE_MAX);
  assign idx       = IDX_W'(col >> LOGN);

  pool_combine #(.IN_RES(IN_RES), .ACC_W(ACC_W)) u_combine (
    .mode       (mode_eff),
    .start      (start),
    .entry      (acc[idx]),
    .pixel      (in_pixel),
    .next_entry (entry_next)
  );

`ifdef STREAM_POOLING_ROUND_EN
  logic [ACC_W:0] rnd_sum;
  always_comb begin
    rnd_sum = ({1'b0, entry_next} + (ACC_W+1)'(N * N / 2)) >> (2 * LOGN);
    if (mode_eff == POOL_MAX)
      avg = entry_next[IN_RES-1:0];
    else if (rnd_sum > (ACC_W+1)'((1 << IN_RES) - 1))
      avg = '1;
    else
      avg = rnd_sum[IN_RES-1:0];
  end
`else
  always_comb begin
    if (mode_eff == POOL_MAX) avg = entry_next[IN_RES-1:0];
    else                      avg = IN_RES'(entry_next >> (2 * LOGN));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      mode_q    <= POOL_AVG;
      for (int i = 0; i < OUT_SIDE; i++) acc[i] <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        acc[idx] <= entry_next;
        if (first_px) mode_q <= mode_eff;
        if (col == SIDE_MAX) begin
          col <= '0;
          row <= (row == SIDE_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // A completion can only be accepted when the output register is free or draining.
      if (done) begin
        out_valid <= 1'b1;
        out_pixel <= OUT_RES'(depth_expand(32'(avg), IN_RES, OUT_RES));
        out_last  <= frame_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_pooling_n.sv
// Directed + random checks of stream_pooling_n against an arithmetic pooling model.
module tb_stream_pooling_n;

  typedef int iq_t[$];
  typedef struct {logic [7:0] px; logic last; int cyc;} obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic [3:0] in_pixel_a;
  logic [7:0] out_pixel_a;
  logic       mode_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [0:0] in_pixel_b;
  logic [7:0] out_pixel_b;

  int   errors = 0, checks = 0, cyc = 0;
  obs_t qa[$], qb[$];
  int   in_cyc_a[$];

  always #5 clk = ~clk;

  stream_pooling_n #(.IN_RES(4), .OUT_RES(8), .N(2), .IN_SIDE(4)) dut_a (
    .clk(clk), .reset(reset), .mode(mode_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pixel(in_pixel_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_pixel(out_pixel_a), .out_last(out_last_a));

  stream_pooling_n #(.IN_RES(1), .OUT_RES(8), .N(4), .IN_SIDE(28)) dut_b (
    .clk(clk), .reset(reset), .mode(mode_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pixel(in_pixel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_pixel(out_pixel_b), .out_last(out_last_b));

  // Inputs change just after the rising edge, so the falling edge sees what the next edge will transfer.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (in_valid_a && in_ready_a)   in_cyc_a.push_back(cyc);
    if (out_valid_a && out_ready_a) qa.push_back('{out_pixel_a, out_last_a, cyc});
    if (out_valid_b && out_ready_b) qb.push_back('{out_pixel_b, out_last_b, cyc});
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic iq_t model(input int side, input int n, input int inres, input int outres,
                                input iq_t px, input logic m);
    iq_t r;
    for (int pr = 0; pr < side / n; pr++)
      for (int pc = 0; pc < side / n; pc++) begin
        int sum, mx, v, a, e, bits;
        sum = 0; mx = 0;
        for (int dr = 0; dr < n; dr++)
          for (int dc = 0; dc < n; dc++) begin
            v = px[(pr * n + dr) * side + pc * n + dc];
            sum += v;
            if (v > mx) mx = v;
          end
`ifdef STREAM_POOLING_ROUND_EN
        a = (sum + n * n / 2) / (n * n);
        if (a > (1 << inres) - 1) a = (1 << inres) - 1;
`else
        a = sum / (n * n);
`endif
        if (m) a = mx;
        e = 0; bits = 0;
        while (bits < outres) begin e = (e << inres) | a; bits += inres; end
        r.push_back(e >> (bits - outres));
      end
    return r;
  endfunction

  task automatic send_a(input iq_t px, input int count, input logic m0, input int flip_at);
    for (int i = 0; i < count; i++) begin
      int w; logic acc;
      w = 0;
      in_valid_a = 1'b1; in_pixel_a = 4'(px[i]);
      mode_a = (flip_at >= 0 && i >= flip_at) ? ~m0 : m0;
      do begin
        @(negedge clk); acc = in_ready_a; @(posedge clk); #1; w++;
      end while (!acc && w < 100);
      if (!acc) begin chk("send_a_timeout", 0, 1); break; end
    end
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input iq_t px, input logic m0);
    for (int i = 0; i < px.size(); i++) begin
      int w; logic acc;
      w = 0;
      in_valid_b = 1'b1; in_pixel_b = 1'(px[i]); mode_b = m0;
      do begin
        @(negedge clk); acc = in_ready_b; @(posedge clk); #1; w++;
      end while (!acc && w < 100);
      if (!acc) begin chk("send_b_timeout", 0, 1); break; end
    end
    in_valid_b = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmp(input string tag, input obs_t q[$], input iq_t exp);
    chk({tag, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      chk($sformatf("%s_px%0d", tag, i), q[i].px, exp[i]);
      chk($sformatf("%s_last%0d", tag, i), q[i].last, (i == exp.size() - 1) ? 1 : 0);
    end
  endtask

  function automatic iq_t rand_frame_a();
    iq_t f;
    for (int i = 0; i < 16; i++) f.push_back(int'($urandom_range(0, 15)));
    return f;
  endfunction

  initial begin
    iq_t f, g, e, fill;
    obs_t q1[$], q2[$];
    logic [7:0] held;
    int w, pool_last[4];

    reset = 1'b1;
    mode_a = 0; in_valid_a = 0; in_pixel_a = '0; out_ready_a = 1;
    mode_b = 0; in_valid_b = 0; in_pixel_b = '0; out_ready_b = 1;
    settle(3);
    reset = 1'b0;
    settle(1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_pixel", out_pixel_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_b_out_valid", out_valid_b, 0);

    // All-0xF frame: four 0xFF outputs, each one cycle after its pool's last pixel.
    for (int i = 0; i < 16; i++) fill.push_back(15);
    qa.delete(); in_cyc_a.delete();
    send_a(fill, 16, 1'b0, -1);
    settle(4);
    cmp("full", qa, model(4, 2, 4, 8, fill, 1'b0));
    pool_last = '{5, 7, 13, 15};
    for (int j = 0; j < 4 && j < qa.size(); j++)
      chk($sformatf("latency%0d", j), qa[j].cyc - in_cyc_a[pool_last[j]], 1);

    // Top-left pool {1,2,3,4} in average then max mode.
    f = rand_frame_a();
    f[0] = 1; f[1] = 2; f[4] = 3; f[5] = 4;
    qa.delete();
    send_a(f, 16, 1'b0, -1);
    send_a(f, 16, 1'b1, -1);
    settle(4);
    chk("qa_size_tl", qa.size(), 8);
    if (qa.size() == 8) begin
`ifdef STREAM_POOLING_ROUND_EN
      chk("tl_avg", qa[0].px, 8'h33);
`else
      chk("tl_avg", qa[0].px, 8'h22);
`endif
      chk("tl_max", qa[4].px, 8'h44);
      cmp("tl_avg_frame", qa[0:3], model(4, 2, 4, 8, f, 1'b0));
      cmp("tl_max_frame", qa[4:7], model(4, 2, 4, 8, f, 1'b1));
    end

    // Backpressure: stall the first output for 5 cycles while input keeps offering.
    f = rand_frame_a();
    qa.delete();
    fork
      send_a(f, 16, 1'b1, -1);
      begin
        w = 0;
        while (!out_valid_a && w < 100) begin @(posedge clk); #1; w++; end
        chk("bp_valid_seen", out_valid_a, 1);
        out_ready_a = 1'b0;
        held = out_pixel_a;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready_a, 0);
          chk("bp_hold_px", out_pixel_a, held);
          chk("bp_hold_valid", out_valid_a, 1);
          @(posedge clk); #1;
        end
        out_ready_a = 1'b1;
      end
    join
    settle(4);
    cmp("bp", qa, model(4, 2, 4, 8, f, 1'b1));

    // Mode flip mid-frame is ignored; the following frame picks up max.
    f = rand_frame_a(); g = rand_frame_a();
    f[0] = 0; f[1] = 15;
    qa.delete();
    send_a(f, 16, 1'b0, 5);
    send_a(g, 16, 1'b1, -1);
    settle(4);
    chk("qa_size_mode", qa.size(), 8);
    if (qa.size() == 8) begin
      cmp("mode_hold", qa[0:3], model(4, 2, 4, 8, f, 1'b0));
      cmp("mode_next", qa[4:7], model(4, 2, 4, 8, g, 1'b1));
    end

    // Reset after 9 pixels discards the partial frame.
    f = rand_frame_a();
    send_a(f, 9, 1'b1, -1);
    reset = 1'b1;
    settle(1);
    reset = 1'b0;
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_ready", in_ready_a, 1);
    qa.delete();
    send_a(fill, 16, 1'b0, -1);
    settle(6);
    cmp("post_rst", qa, model(4, 2, 4, 8, fill, 1'b0));

    // 28x28 binary frames with N=4, pools biased to all-ones, all-zeros or random.
    for (int m = 0; m < 2; m++) begin
      int kind[49];
      g.delete();
      foreach (kind[k]) kind[k] = int'($urandom_range(0, 2));
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++)
          case (kind[(r / 4) * 7 + c / 4])
            0: g.push_back(1);
            1: g.push_back(0);
            default: g.push_back(int'($urandom_range(0, 1)));
          endcase
      qb.delete();
      send_b(g, m[0]);
      settle(4);
      e = model(28, 4, 1, 8, g, m[0]);
      cmp(m == 0 ? "big_avg" : "big_max", qb, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
